// File: rtl/ni_flit_injector.sv
// Network-interface flit injector: packs packet requests and body payloads into
// head/body/tail flits for one router input port, with per-VC credit flow control.
module ni_flit_injector #(
    parameter int V       = 2,
    parameter int B       = 4,
    parameter int Fw      = 32,
    parameter int MAX_LEN = 16,
    localparam int VW     = (V > 1) ? $clog2(V) : 1,
    localparam int PLw    = Fw - 2 - VW,
    localparam int LENw   = $clog2(MAX_LEN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pkt_valid,
    output logic            pkt_ready,
    input  logic [VW-1:0]   pkt_vc,
    input  logic [LENw-1:0] pkt_len,
    input  logic [PLw-1:0]  pkt_hdr,
    input  logic            dat_valid,
    output logic            dat_ready,
    input  logic [PLw-1:0]  dat_payload,
    output logic [Fw-1:0]   flit_out,
    output logic            flit_out_wr,
    input  logic [V-1:0]    credit_in,
    output logic            busy,
    output logic            credit_err
);

    localparam int CW = $clog2(B + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [LENw-1:0] remaining_q, remaining_d;
    logic [VW-1:0]   cur_vc_q, cur_vc_d;
    logic [Fw-1:0]   flit_out_q, flit_out_d;
    logic            flit_out_wr_q, flit_out_wr_d;
    logic            credit_err_q, credit_err_d;
    logic [CW-1:0]   cnt_q [V];
    logic [CW-1:0]   cnt_d [V];

    logic [LENw-1:0] eff_len;
    logic            pkt_vc_ok;
    logic            cur_vc_ok;
    logic            send;
    logic [VW-1:0]   send_vc;
    logic            dec;

    always_comb begin
        if (pkt_len == '0) begin
            eff_len = LENw'(1);
        end else if (pkt_len > LENw'(MAX_LEN)) begin
            eff_len = LENw'(MAX_LEN);
        end else begin
            eff_len = pkt_len;
        end
    end

    // Credit availability uses only the registered count, so a credit returned
    // this cycle cannot enable a send in the same cycle.
    always_comb begin
        pkt_vc_ok = 1'b0;
        cur_vc_ok = 1'b0;
        if (int'(pkt_vc) < V) begin
            pkt_vc_ok = (cnt_q[pkt_vc] != '0);
        end
        if (int'(cur_vc_q) < V) begin
            cur_vc_ok = (cnt_q[cur_vc_q] != '0);
        end
    end

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        cur_vc_d      = cur_vc_q;
        flit_out_d    = flit_out_q;
        flit_out_wr_d = 1'b0;
        pkt_ready     = 1'b0;
        dat_ready     = 1'b0;
        send          = 1'b0;
        send_vc       = cur_vc_q;

        unique case (state_q)
            IDLE: begin
                pkt_ready = !reset && pkt_valid && pkt_vc_ok;
                if (pkt_ready) begin
                    send          = 1'b1;
                    send_vc       = pkt_vc;
                    flit_out_wr_d = 1'b1;
                    flit_out_d    = {1'b1, (eff_len == LENw'(1)), pkt_vc, pkt_hdr};
                    if (eff_len != LENw'(1)) begin
                        cur_vc_d    = pkt_vc;
                        remaining_d = eff_len - LENw'(1);
                        state_d     = BODY;
                    end
                end
            end
            BODY: begin
                dat_ready = !reset && dat_valid && cur_vc_ok;
                if (dat_ready) begin
                    send          = 1'b1;
                    flit_out_wr_d = 1'b1;
                    flit_out_d    = {1'b0, (remaining_q == LENw'(1)), cur_vc_q, dat_payload};
                    remaining_d   = remaining_q - LENw'(1);
                    if (remaining_q == LENw'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A send and a returned credit on the same VC cancel out.
    always_comb begin
        credit_err_d = credit_err_q;
        dec          = 1'b0;
        for (int unsigned v = 0; v < V; v++) begin
            cnt_d[v] = cnt_q[v];
            dec      = send && (send_vc == VW'(v));
            if (credit_in[v] && !dec) begin
                if (cnt_q[v] == CW'(B)) begin
                    credit_err_d = 1'b1;
                end else begin
                    cnt_d[v] = cnt_q[v] + CW'(1);
                end
            end else if (dec && !credit_in[v]) begin
                cnt_d[v] = cnt_q[v] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            remaining_q   <= '0;
            cur_vc_q      <= '0;
            flit_out_q    <= '0;
            flit_out_wr_q <= 1'b0;
            credit_err_q  <= 1'b0;
            for (int unsigned v = 0; v < V; v++) begin
                cnt_q[v] <= CW'(B);
            end
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            cur_vc_q      <= cur_vc_d;
            flit_out_q    <= flit_out_d;
            flit_out_wr_q <= flit_out_wr_d;
            credit_err_q  <= credit_err_d;
            for (int unsigned v = 0; v < V; v++) begin
                cnt_q[v] <= cnt_d[v];
            end
        end
    end

    assign flit_out    = flit_out_q;
    assign flit_out_wr = flit_out_wr_q;
    assign busy        = (state_q != IDLE);
    assign credit_err  = credit_err_q;

endmodule

// File: tb/tb_ni_flit_injector.sv
// Scoreboard bench for ni_flit_injector: a behavioural model predicts handshakes,
// credits and flits; the monitor pops expected flits as the DUT strobes them.
module tb_ni_flit_injector;

    localparam int V       = 2;
    localparam int B       = 4;
    localparam int FW      = 32;
    localparam int MAX_LEN = 16;
    localparam int VW      = 1;
    localparam int PLW     = FW - 2 - VW;
    localparam int LENW    = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            pkt_valid;
    logic            pkt_ready;
    logic [VW-1:0]   pkt_vc;
    logic [LENW-1:0] pkt_len;
    logic [PLW-1:0]  pkt_hdr;
    logic            dat_valid;
    logic            dat_ready;
    logic [PLW-1:0]  dat_payload;
    logic [FW-1:0]   flit_out;
    logic            flit_out_wr;
    logic [V-1:0]    credit_in;
    logic            busy;
    logic            credit_err;

    ni_flit_injector #(.V(V), .B(B), .Fw(FW), .MAX_LEN(MAX_LEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_vc      (pkt_vc),
        .pkt_len     (pkt_len),
        .pkt_hdr     (pkt_hdr),
        .dat_valid   (dat_valid),
        .dat_ready   (dat_ready),
        .dat_payload (dat_payload),
        .flit_out    (flit_out),
        .flit_out_wr (flit_out_wr),
        .credit_in   (credit_in),
        .busy        (busy),
        .credit_err  (credit_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] last_flit = '0;

    int m_cnt [V];
    bit m_body;
    int m_rem;
    int m_vc;
    bit m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every accepted flit must strobe on the very next edge; otherwise flit_out holds.
    always @(posedge clk) begin
        #1;
        if (flit_out_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_wr", flit_out_wr, 1'b0);
            end else begin
                last_flit = exp_q.pop_front();
                check("flit", flit_out, last_flit);
            end
        end else begin
            if (exp_q.size() != 0) begin
                check("missing_wr", flit_out_wr, 1'b1);
                void'(exp_q.pop_front());
            end
            check("flit_hold", flit_out, last_flit);
        end
    end

    task automatic model_reset();
        for (int v = 0; v < V; v++) m_cnt[v] = B;
        m_body = 0;
        m_rem  = 0;
        m_vc   = 0;
        m_err  = 0;
    endtask

    task automatic tick(input bit pv, input int vc, input int len, input int hdr,
                        input bit dv, input int pay, input logic [V-1:0] cr);
        bit            ep, ed, send, inc, dec;
        int            eff, svc;
        logic [VW-1:0] vcl;
        logic [PLW-1:0] pl;
        logic [FW-1:0] f;
        pkt_valid   = pv;
        pkt_vc      = VW'(vc);
        pkt_len     = LENW'(len);
        pkt_hdr     = PLW'(hdr);
        dat_valid   = dv;
        dat_payload = PLW'(pay);
        credit_in   = cr;
        @(negedge clk);
        ep = !m_body && pv && (m_cnt[vc] != 0);
        ed = m_body && dv && (m_cnt[m_vc] != 0);
        check("pkt_ready", pkt_ready, ep);
        check("dat_ready", dat_ready, ed);
        send = 0;
        svc  = 0;
        if (ep) begin
            eff = (len == 0) ? 1 : ((len > MAX_LEN) ? MAX_LEN : len);
            vcl = VW'(vc);
            pl  = PLW'(hdr);
            f   = {1'b1, (eff == 1), vcl, pl};
            exp_q.push_back(f);
            send = 1;
            svc  = vc;
            if (eff > 1) begin
                m_body = 1;
                m_rem  = eff - 1;
                m_vc   = vc;
            end
        end else if (ed) begin
            vcl = VW'(m_vc);
            pl  = PLW'(pay);
            f   = {1'b0, (m_rem == 1), vcl, pl};
            exp_q.push_back(f);
            send = 1;
            svc  = m_vc;
            m_rem--;
            if (m_rem == 0) m_body = 0;
        end
        for (int v = 0; v < V; v++) begin
            inc = cr[v];
            dec = send && (svc == v);
            if (inc && !dec) begin
                if (m_cnt[v] == B) m_err = 1;
                else m_cnt[v]++;
            end else if (dec && !inc) begin
                m_cnt[v]--;
            end
        end
        @(posedge clk);
        #1;
        check("busy", busy, m_body);
        check("credit_err", credit_err, m_err);
        for (int v = 0; v < V; v++) check("cnt", dut.cnt_q[v], m_cnt[v]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1;
        #1;
        check("rst_flit_out", flit_out, '0);
        check("rst_wr", flit_out_wr, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", credit_err, 1'b0);
        check("rst_pkt_ready", pkt_ready, 1'b0);
        check("rst_dat_ready", dat_ready, 1'b0);
        for (int v = 0; v < V; v++) check("rst_cnt", dut.cnt_q[v], B);
        exp_q.delete();
        last_flit = '0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_pkt_ready_hold", pkt_ready, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        pkt_valid   = 1'b1;
        pkt_vc      = '0;
        pkt_len     = LENW'(1);
        pkt_hdr     = '0;
        dat_valid   = 1'b1;
        dat_payload = '0;
        credit_in   = '0;
        model_reset();
        do_reset();
        idle(1);

        // single-flit packet on VC1
        tick(1, 1, 1, 'h5, 0, 0, '0);
        check("single_cnt1", dut.cnt_q[1], 3);
        idle(1);
        tick(0, 0, 0, 0, 0, 0, 2'b10);

        // 4-flit packet on VC0, payload streaming
        tick(1, 0, 4, 'hA, 1, 'h100, '0);
        for (int i = 1; i < 4; i++) tick(0, 0, 0, 0, 1, 'h100 + i, '0);
        check("four_cnt0", dut.cnt_q[0], 0);
        check("four_busy", busy, 1'b0);

        // refill VC0, then credit stall inside a 5-flit packet
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0, 2'b01);
        tick(1, 0, 5, 'h1F, 1, 'h200, '0);
        for (int i = 1; i < 4; i++) tick(0, 0, 0, 0, 1, 'h200 + i, '0);
        tick(0, 0, 0, 0, 1, 'h2AA, '0);
        check("stall_dat_ready", dat_ready, 1'b0);
        tick(0, 0, 0, 0, 1, 'h2AB, 2'b01);
        tick(0, 0, 0, 0, 1, 'h2AC, '0);
        check("resume_busy", busy, 1'b0);

        // send and credit on same VC cancel; credit overflow is sticky
        tick(0, 0, 0, 0, 0, 0, 2'b01);
        tick(0, 0, 0, 0, 0, 0, 2'b01);
        tick(1, 0, 1, 'h33, 0, 0, 2'b01);
        check("cancel_cnt0", dut.cnt_q[0], 2);
        tick(0, 0, 0, 0, 0, 0, 2'b10);
        check("overflow_cnt1", dut.cnt_q[1], 4);
        check("overflow_err", credit_err, 1'b1);
        idle(2);
        check("overflow_sticky", credit_err, 1'b1);

        // zero length becomes single flit; oversize saturates to MAX_LEN
        tick(1, 1, 0, 'h77, 0, 0, '0);
        tick(1, 1, 31, 'h1234, 0, 0, 2'b10);
        for (int i = 1; i < MAX_LEN; i++) tick(0, 0, 0, 0, 1, 'h300 + i, 2'b10);
        check("sat_busy", busy, 1'b0);
        tick(0, 0, 0, 0, 0, 0, 2'b10);

        // reset during the 2nd body flit of a 6-flit packet
        for (int i = 0; i < 2; i++) tick(0, 0, 0, 0, 0, 0, 2'b01);
        tick(1, 0, 6, 'h66, 1, 'h400, '0);
        tick(0, 0, 0, 0, 1, 'h401, '0);
        dat_valid = 1'b1;
        do_reset();
        tick(0, 0, 0, 0, 1, 'h402, '0);
        check("abandon_busy", busy, 1'b0);
        tick(1, 0, 1, 'h99, 1, 'h403, '0);
        idle(2);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
